// File: rtl/rv_mc_sequencer.sv
// Multi-cycle RV32I sequencer: owns PC, instruction register and the
// fetch/decode/exec/mem/write-back FSM, with req/ack memories that may insert wait states.
module rv_mc_sequencer #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              MAX_WAIT = 15
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ack,
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic            dec_load,
    input  logic            dec_store,
    input  logic            dec_reg_we,
    input  logic            dec_pc_sel,
    input  logic            dec_illegal,
    input  logic [XLEN-1:0] alu_out,
    input  logic [XLEN-1:0] rs2_data,
    output logic [XLEN-1:0] pc,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] alu_reg,
    output logic [XLEN-1:0] mdr,
    output logic            rf_we,
    output logic            retire,
    output logic            trap,
    output logic [2:0]      state
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd5;

    localparam int              WW         = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0]   TIMEOUT_AT = WW'(MAX_WAIT - 1);

    logic [2:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     inst_q, inst_d;
    logic [XLEN-1:0] alu_reg_q, alu_reg_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] mdr_q, mdr_d;
    logic [WW-1:0]   wait_q, wait_d;
    logic [XLEN-1:0] next_pc;
    logic            timeout;

    // Handshake: a request is held high with stable address/data from state
    // entry through the ack cycle inclusive; the transfer completes on the
    // rising edge where req and ack are both high, and acks seen without a
    // request are ignored.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        alu_reg_d = alu_reg_q;
        wdata_d   = wdata_q;
        mdr_d     = mdr_q;
        wait_d    = '0;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        rf_we     = 1'b0;
        retire    = 1'b0;
        next_pc   = dec_pc_sel ? alu_reg_q : pc_q + XLEN'(4);
        // Last tolerated wait cycle; an ack here still wins.
        timeout   = (wait_q == TIMEOUT_AT);

        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    inst_d  = imem_rdata;
                    state_d = S_DECODE;
                end else if (timeout) begin
                    state_d = S_TRAP;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            S_DECODE: state_d = dec_illegal ? S_TRAP : S_EXEC;
            S_EXEC: begin
                alu_reg_d = alu_out;
                wdata_d   = rs2_data;
                state_d   = (dec_load | dec_store) ? S_MEM : S_WB;
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = dec_store;
                if (dmem_ack) begin
                    if (dec_load) mdr_d = dmem_rdata;
                    state_d = S_WB;
                end else if (timeout) begin
                    state_d = S_TRAP;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            S_WB: begin
                rf_we = dec_reg_we & ~dec_store;
                if (next_pc[1:0] != 2'b00) begin
                    state_d = S_TRAP;
                end else begin
                    pc_d    = next_pc;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            inst_q    <= '0;
            alu_reg_q <= '0;
            wdata_q   <= '0;
            mdr_q     <= '0;
            wait_q    <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            alu_reg_q <= alu_reg_d;
            wdata_q   <= wdata_d;
            mdr_q     <= mdr_d;
            wait_q    <= wait_d;
        end
    end

    assign imem_addr  = pc_q;
    assign dmem_addr  = alu_reg_q;
    assign dmem_wdata = wdata_q;
    assign pc         = pc_q;
    assign inst       = inst_q;
    assign alu_reg    = alu_reg_q;
    assign mdr        = mdr_q;
    assign trap       = (state_q == S_TRAP);
    assign state      = state_q;

endmodule

// File: tb/tb_rv_mc_sequencer.sv
// Bench for rv_mc_sequencer: acts as memories and decoder, and predicts each
// instruction's state trace, handshake counts and architectural results.
module tb_rv_mc_sequencer;

    localparam int          XLEN     = 32;
    localparam int          MAX_WAIT = 15;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dec_load, dec_store, dec_reg_we, dec_pc_sel, dec_illegal;
    logic [31:0] alu_out, rs2_data;
    logic [31:0] pc, inst, alu_reg, mdr;
    logic        rf_we, retire, trap;
    logic [2:0]  state;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0]     m_pc;
    logic [31:0]     m_mdr;
    logic [XLEN-1:0] exp_q[$];

    rv_mc_sequencer #(.XLEN(XLEN), .RESET_PC(RESET_PC), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .dec_load(dec_load), .dec_store(dec_store), .dec_reg_we(dec_reg_we),
        .dec_pc_sel(dec_pc_sel), .dec_illegal(dec_illegal),
        .alu_out(alu_out), .rs2_data(rs2_data),
        .pc(pc), .inst(inst), .alu_reg(alu_reg), .mdr(mdr),
        .rf_we(rf_we), .retire(retire), .trap(trap), .state(state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] push_st(input logic [31:0] h, input logic [3:0] s);
        return {h[27:0], s};
    endfunction

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_state"},   32'(state), 32'd0);
        check_eq({pfx, "_pc"},      pc, RESET_PC);
        check_eq({pfx, "_inst"},    inst, 32'd0);
        check_eq({pfx, "_alu_reg"}, alu_reg, 32'd0);
        check_eq({pfx, "_mdr"},     mdr, 32'd0);
        check_eq({pfx, "_wdata"},   dmem_wdata, 32'd0);
        check_eq({pfx, "_trap"},    32'(trap), 32'd0);
        check_eq({pfx, "_imem_req"}, 32'(imem_req), 32'd1);
        check_eq({pfx, "_dmem_req"}, 32'(dmem_req), 32'd0);
        check_eq({pfx, "_rf_we"},   32'(rf_we), 32'd0);
        check_eq({pfx, "_retire"},  32'(retire), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        m_pc = RESET_PC;
        m_mdr = 32'd0;
        exp_q.delete();
    endtask

    // ---------------- driver + reference model ----------------
    // Starts at a falling edge with the DUT in FETCH. iwait/dwait are the
    // number of wait cycles before the memory acks; >= MAX_WAIT never acks.
    task automatic run_instr(input logic [31:0] word, input logic ld, input logic st,
                             input logic rwe, input logic psel, input logic ill,
                             input logic [31:0] alu, input logic [31:0] rs2,
                             input logic [31:0] rdata, input int iwait, input int dwait);
        int exp_ireq, exp_dreq, exp_cycles, exp_rfwe, exp_ret;
        int ireq_n, dreq_n, rfwe_n, ret_n, ret_cyc, cyc, bad_addr, bad_dmem;
        logic exp_trap, done;
        logic [31:0] npc, exp_hist, act_hist, exp_mdr;

        exp_trap = 1'b0; exp_ret = 0; exp_rfwe = 0; exp_dreq = 0; exp_cycles = 0;
        exp_hist = 32'd0; npc = m_pc; exp_mdr = m_mdr;
        exp_ireq = (iwait >= MAX_WAIT) ? MAX_WAIT : iwait + 1;
        for (int i = 0; i < exp_ireq; i++) begin exp_hist = push_st(exp_hist, 4'd0); exp_cycles++; end
        if (iwait >= MAX_WAIT) begin
            exp_trap = 1'b1;
        end else begin
            exp_hist = push_st(exp_hist, 4'd1); exp_cycles++;
            if (ill) begin
                exp_trap = 1'b1;
            end else begin
                exp_hist = push_st(exp_hist, 4'd2); exp_cycles++;
                if (ld || st) begin
                    exp_dreq = (dwait >= MAX_WAIT) ? MAX_WAIT : dwait + 1;
                    for (int i = 0; i < exp_dreq; i++) begin exp_hist = push_st(exp_hist, 4'd3); exp_cycles++; end
                    if (dwait >= MAX_WAIT) exp_trap = 1'b1;
                    else if (ld) exp_mdr = rdata;
                end
                if (!exp_trap) begin
                    exp_hist = push_st(exp_hist, 4'd4); exp_cycles++;
                    exp_rfwe = (rwe && !st) ? 1 : 0;
                    npc = psel ? alu : m_pc + 32'd4;
                    if (npc[1:0] != 2'b00) begin
                        exp_trap = 1'b1;
                    end else begin
                        exp_ret = 1;
                        exp_q.push_back(npc);
                    end
                end
            end
        end

        imem_rdata = word; dec_load = ld; dec_store = st; dec_reg_we = rwe;
        dec_pc_sel = psel; dec_illegal = ill; alu_out = alu; rs2_data = rs2; dmem_rdata = rdata;

        ireq_n = 0; dreq_n = 0; rfwe_n = 0; ret_n = 0; ret_cyc = 0;
        bad_addr = 0; bad_dmem = 0; act_hist = 32'd0; done = 1'b0;
        for (cyc = 0; cyc < 100; cyc++) begin
            if (ret_cyc > 0 || state == 3'd5) begin done = 1'b1; break; end
            act_hist = push_st(act_hist, {1'b0, state});
            if (imem_req) begin
                if (imem_addr !== m_pc) bad_addr++;
                imem_ack = (ireq_n == iwait);
                ireq_n++;
            end else begin
                imem_ack = 1'($urandom_range(0, 1));
            end
            if (dmem_req) begin
                if (dmem_addr !== alu || dmem_we !== st || dmem_wdata !== rs2) bad_dmem++;
                dmem_ack = (dreq_n == dwait);
                dreq_n++;
            end else begin
                dmem_ack = 1'($urandom_range(0, 1));
            end
            if (rf_we) rfwe_n++;
            if (retire) begin ret_n++; ret_cyc = cyc + 1; end
            @(negedge clk);
        end

        check_eq("finished", 32'(done), 32'd1);
        check_eq("cycles", cyc, exp_cycles);
        check_eq("state_trace", act_hist, exp_hist);
        check_eq("imem_req_cycles", ireq_n, exp_ireq);
        check_eq("dmem_req_cycles", dreq_n, exp_dreq);
        check_eq("imem_addr_bad", bad_addr, 0);
        check_eq("dmem_fields_bad", bad_dmem, 0);
        check_eq("rf_we_pulses", rfwe_n, exp_rfwe);
        check_eq("retire_pulses", ret_n, exp_ret);
        check_eq("trap", 32'(trap), 32'(exp_trap));
        if (iwait < MAX_WAIT) check_eq("inst", inst, word);
        check_eq("mdr", mdr, exp_mdr);
        m_mdr = exp_mdr;
        if (exp_ret != 0) begin
            check_eq("retire_cycle", ret_cyc, exp_cycles);
            check_eq("pc", pc, exp_q.pop_front());
            m_pc = npc;
        end else begin
            check_eq("pc_held", pc, m_pc);
        end
        if (exp_trap) begin
            check_eq("trap_imem_req", 32'(imem_req), 32'd0);
            check_eq("trap_dmem_req", 32'(dmem_req), 32'd0);
            repeat (4) @(negedge clk);
            check_eq("trap_sticky_state", 32'(state), 32'd5);
            check_eq("trap_sticky_flag", 32'(trap), 32'd1);
            check_eq("trap_sticky_retire", 32'(retire), 32'd0);
        end
    endtask

    // Load that never gets a data ack; reset drops in its second MEM cycle.
    task automatic abort_in_mem();
        int dreq_n;
        imem_rdata = 32'h0000_2083; dec_load = 1'b1; dec_store = 1'b0; dec_reg_we = 1'b1;
        dec_pc_sel = 1'b0; dec_illegal = 1'b0; alu_out = 32'h300; rs2_data = 32'h55;
        dmem_rdata = 32'hCAFE_F00D;
        dreq_n = 0;
        for (int c = 0; c < 50; c++) begin
            if (dmem_req) dreq_n++;
            imem_ack = imem_req;
            dmem_ack = 1'b0;
            if (dreq_n == 2) break;
            @(negedge clk);
        end
        check_eq("abort_reached_mem", dreq_n, 2);
        #2 rst = 1'b0;
        #1 check_reset_outputs("abort");
        @(negedge clk);
        check_eq("abort_no_rf_we", 32'(rf_we), 32'd0);
        rst = 1'b1;
        m_pc = RESET_PC;
        m_mdr = 32'd0;
        exp_q.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        imem_ack = 1'b0; imem_rdata = '0; dmem_ack = 1'b0; dmem_rdata = '0;
        dec_load = 1'b0; dec_store = 1'b0; dec_reg_we = 1'b0; dec_pc_sel = 1'b0; dec_illegal = 1'b0;
        alu_out = '0; rs2_data = '0;
        m_pc = RESET_PC; m_mdr = 32'd0;

        #1 check_reset_outputs("reset");
        do_reset();

        run_instr(32'h0050_0093, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd5, 32'd0, 32'd0, 0, 0);
        run_instr(32'h0000_2103, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 32'd0, 32'h1234_5678, 0, 3);
        run_instr(32'h0020_2023, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h200, 32'hDEAD_BEEF, 32'd0, 0, 0);
        run_instr(32'h0000_0063, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h40, 32'd0, 32'd0, 0, 0);

        for (int k = 0; k < 40; k++) begin
            int kind, iw, dw;
            logic [31:0] a, r2, rd, word;
            logic rwe;
            kind = $urandom_range(0, 3); iw = $urandom_range(0, 3); dw = $urandom_range(0, 4);
            a = $urandom; r2 = $urandom; rd = $urandom; word = $urandom;
            rwe = 1'($urandom_range(0, 1));
            case (kind)
                0: run_instr(word, 1'b0, 1'b0, rwe, 1'b0, 1'b0, a, r2, rd, iw, dw);
                1: run_instr(word, 1'b1, 1'b0, rwe, 1'b0, 1'b0, a, r2, rd, iw, dw);
                2: run_instr(word, 1'b0, 1'b1, rwe, 1'b0, 1'b0, a, r2, rd, iw, dw);
                default: run_instr(word, 1'b0, 1'b0, rwe, 1'b1, 1'b0, a & 32'h0000_FFFC, r2, rd, iw, dw);
            endcase
        end

        // Misaligned branch target traps without retiring.
        run_instr(32'h0000_0063, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h42, 32'd0, 32'd0, 0, 0);
        do_reset();

        // Ack in the final tolerated cycle, then no ack at all.
        run_instr(32'h0010_0093, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd1, 32'd0, 32'd0, MAX_WAIT - 1, 0);
        run_instr(32'h0010_0093, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd1, 32'd0, 32'd0, MAX_WAIT, 0);
        do_reset();

        run_instr(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0, 32'd0, 32'd0, 1, 0);
        do_reset();

        run_instr(32'h0000_2103, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h80, 32'd0, 32'h77, 0, MAX_WAIT - 1);
        run_instr(32'h0000_2103, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h80, 32'd0, 32'h99, 0, MAX_WAIT);
        do_reset();

        run_instr(32'h0000_2103, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h200, 32'd0, 32'h1234_5678, 0, 0);
        abort_in_mem();
        run_instr(32'h0050_0093, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd5, 32'd0, 32'd0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rv_mc_sequencer.md
# rv_mc_sequencer

Multi-cycle execution sequencer for the RV32I core: owns the PC, instruction register and the fetch/decode/execute/memory/write-back state machine. It replaces the single-cycle flow, where every instruction finished in one clock against zero-wait memories, with a handshaked req/ack interface to instruction and data memory that tolerates wait states. Decode (`ID`), register file, branch compare, ALU (`EX`) and write-back mux remain external and are driven from the latched values this block holds.

## Interface
- `XLEN`, 32: datapath/address width.
- `RESET_PC`, 0: PC value loaded on reset; must be 4-byte aligned.
- `MAX_WAIT`, 15: memory wait cycles tolerated before trap; ≥1.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `imem_req` out 1: fetch request.
- `imem_addr` out XLEN: fetch address, always equal to `pc`.
- `imem_ack` in 1: fetch complete; `imem_rdata` valid.
- `imem_rdata` in 32: instruction word.
- `dmem_req` out 1: data access request.
- `dmem_we` out 1: 1 = store.
- `dmem_addr` out XLEN: latched ALU result.
- `dmem_wdata` out XLEN: latched rs2 data.
- `dmem_ack` in 1: data access complete.
- `dmem_rdata` in XLEN: load data.
- `dec_load`, `dec_store`, `dec_reg_we`, `dec_pc_sel`, `dec_illegal` in 1 each: decoder controls for `inst`.
- `alu_out` in XLEN: ALU result.
- `rs2_data` in XLEN: register file read port 2.
- `pc` out XLEN: current PC.
- `inst` out 32: instruction register.
- `alu_reg` out XLEN: ALU result latched in EXEC.
- `mdr` out XLEN: load data register.
- `rf_we` out 1: register file write enable.
- `retire` out 1: one-cycle pulse per completed instruction.
- `trap` out 1: sticky fault flag.
- `state` out 3: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.

## Operation
- FETCH: `imem_req`=1. On `imem_ack`, `inst`←`imem_rdata` and go to DECODE. If the wait count reaches `MAX_WAIT` without an ack, go to TRAP.
- DECODE: one cycle for register file read. Go to TRAP if `dec_illegal`, otherwise to EXEC.
- EXEC: one cycle. `alu_reg`←`alu_out` and `dmem_wdata` reg←`rs2_data`. Go to MEM if `dec_load|dec_store`, otherwise to WB.
- MEM: `dmem_req`=1 and `dmem_we`=`dec_store`.
  - On ack for a load: `mdr`←`dmem_rdata`.
  - On ack for either access: go to WB.
  - Wait-count timeout: go to TRAP.
- WB:
  - `rf_we`=`dec_reg_we & ~dec_store`.
  - Next PC is `dec_pc_sel ? alu_reg : pc+4`, wrapping modulo 2^XLEN.
  - If next PC[1:0]≠0: go to TRAP and leave PC unchanged. Otherwise update PC, pulse `retire` and go to FETCH.
- TRAP: all requests, `rf_we` and `retire` are 0, `trap`=1. The block stays here until reset.
- Wait counter:
  - Width is clog2(MAX_WAIT+1).
  - Clears on entry to FETCH or MEM; increments each cycle the request is held without ack.
  - An ack arriving in the timeout cycle wins over the timeout.
- Stray acks, i.e. `imem_ack`/`dmem_ack` while the matching request is 0, are ignored.
- Decoder inputs are sampled only in DECODE, EXEC, MEM and WB; they must remain stable while `inst` is stable.

## Timing
- Reset values (asynchronous): `pc`=RESET_PC, `inst`=0, `alu_reg`=0, `mdr`=0, `dmem_wdata`=0, `trap`=0, `state`=FETCH, wait counter=0.
- Combinational outputs follow these reset values, so `imem_req`=1 while in FETCH, including during reset; the memory must qualify requests with reset.
- Request handshake:
  - The request rises on state entry and holds, with address/data stable, until the ack cycle inclusive.
  - It drops in the cycle after the ack.
  - An ack in the same cycle the request first rises completes the transfer (zero-wait).
- Latency with zero-wait memory:
  - ALU and branch instructions: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Loads and stores: 5 cycles.
  - Each memory wait cycle adds 1.
- `rf_we` and `retire` are asserted only in WB, each for exactly one cycle. The register file writes on the rising edge that ends WB.
- Reset asserted mid-instruction aborts it immediately with no write-back. A request in flight is dropped; the memory must tolerate this.

## Test plan
- **ALU sequence:** reset with RESET_PC=0 and zero-wait imem, then `addi`, `dec_reg_we`=1 → state 0,1,2,4; `retire` pulses in cycle 4; `pc`=4; `rf_we` high one cycle.
- **Load with waits:** load, `alu_out`=0x100, `dmem_ack` after 3 wait cycles → `dmem_addr`=0x100 held 4 cycles; `mdr`=`dmem_rdata`; total 8 cycles; `rf_we`=1.
- **Store:** store, `rs2_data`=0xDEADBEEF → `dmem_we`=1 and `dmem_wdata`=0xDEADBEEF in MEM; `rf_we`=0 in WB; `pc`+=4.
- **Taken branch:** `dec_pc_sel`=1, `alu_out`=0x40 → `pc`=0x40 after WB. With `alu_out`=0x42 → `trap`=1, `pc` unchanged, no `retire`.
- **Timeout vs late ack:** no `imem_ack` for MAX_WAIT=15 cycles → TRAP, `imem_req`=0, sticky until reset. An ack exactly on cycle 15 instead proceeds to DECODE.
- **Reset abort and illegal instruction:**
  - Assert `rst`=0 mid-MEM → outputs immediately return to reset values; after release fetch restarts at RESET_PC.
  - `dec_illegal`=1 → TRAP after DECODE.
